// File: rtl/writeback_unit.sv
// Final pipeline stage: commits ALU results or load data to the register file
// and tracks in-flight destination writes with a per-register 2-bit scoreboard.
module writeback_unit #(
  parameter int WIDTH        = 8,
  parameter int REGNUM       = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int MEMTIMEOUT   = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issueEnable,
  input  logic [ADDRESSWIDTH-1:0] issueAddress,
  output logic                    issueFull,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic                    inRegWrite,
  input  logic                    inMemToReg,
  input  logic [ADDRESSWIDTH-1:0] inWriteAddress,
  input  logic [WIDTH-1:0]        inAluResult,
  input  logic                    memDataValid,
  input  logic [WIDTH-1:0]        memData,
  input  logic [ADDRESSWIDTH-1:0] reg1Address,
  input  logic [ADDRESSWIDTH-1:0] reg2Address,
  output logic                    reg1Busy,
  output logic                    reg2Busy,
  output logic                    writeEnable,
  output logic [ADDRESSWIDTH-1:0] writeAddress,
  output logic [WIDTH-1:0]        dataToSave,
  output logic [REGNUM-1:0]       pendingMask,
  output logic                    memError
);

  localparam int TW = (MEMTIMEOUT > 2) ? $clog2(MEMTIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDRESSWIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]        data_reg;
  logic [TW-1:0]           timer_reg;
  logic                    memerror_reg;

  logic                    accept;
  logic                    timeout;
  logic                    dec_en;
  logic [1:0]              cnt [REGNUM];

  assign accept  = inValid && inReady;
  assign timeout = (state_reg == WAIT_MEM) && !memDataValid &&
                   (timer_reg == TW'(MEMTIMEOUT - 1));
  // Both a commit and a load abort retire the latched destination.
  assign dec_en  = (state_reg == COMMIT) || timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE, COMMIT: begin
        if (accept && inRegWrite) begin
          state_next = inMemToReg ? WAIT_MEM : COMMIT;
        end
      end
      WAIT_MEM: begin
        if (memDataValid) begin
          state_next = COMMIT;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_MEM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    inReady     = (state_reg != WAIT_MEM);
    writeEnable = (state_reg == COMMIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      timer_reg    <= '0;
      memerror_reg <= 1'b0;
    end else begin
      if (accept && inRegWrite) begin
        addr_reg <= inWriteAddress;
        if (!inMemToReg) begin
          data_reg <= inAluResult;
        end
      end
      if (state_reg == WAIT_MEM && memDataValid) begin
        data_reg <= memData;
      end
      if (accept) begin
        timer_reg <= '0;
      end else if (state_reg == WAIT_MEM && !memDataValid) begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (timeout) begin
        memerror_reg <= 1'b1;
      end
    end
  end

  assign writeAddress = addr_reg;
  assign dataToSave   = data_reg;
  assign memError     = memerror_reg;

  generate
    for (genvar gi = 0; gi < REGNUM; gi++) begin : g_sb
      logic [1:0] cnt_reg;
      logic       inc;
      logic       dec;

      assign inc = issueEnable && (issueAddress == ADDRESSWIDTH'(gi));
      assign dec = dec_en && (addr_reg == ADDRESSWIDTH'(gi));

      // A simultaneous issue and retire cancel out, even at saturation,
      // since the retire frees the slot the issue would take.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= 2'd0;
        end else if (inc && !dec && cnt_reg != 2'd3) begin
          cnt_reg <= cnt_reg + 2'd1;
        end else if (dec && !inc && cnt_reg != 2'd0) begin
          cnt_reg <= cnt_reg - 2'd1;
        end
      end

      assign cnt[gi]         = cnt_reg;
      assign pendingMask[gi] = (cnt_reg != 2'd0);
    end
  endgenerate

  assign issueFull = (cnt[issueAddress] == 2'd3);
  assign reg1Busy  = pendingMask[reg1Address];
  assign reg2Busy  = pendingMask[reg2Address];

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: hand vector table, directed corner sequences and
// a randomized run checked every cycle against a behavioural model.
module tb_writeback_unit;
  localparam int WIDTH = 8;
  localparam int REGNUM = 8;
  localparam int AW = 3;
  localparam int MT = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             issueEnable, issueFull, inValid, inReady, inRegWrite, inMemToReg;
  logic [AW-1:0]    issueAddress, inWriteAddress, reg1Address, reg2Address, writeAddress;
  logic [WIDTH-1:0] inAluResult, memData, dataToSave;
  logic             memDataValid, reg1Busy, reg2Busy, writeEnable, memError;
  logic [REGNUM-1:0] pendingMask;

  writeback_unit #(.WIDTH(WIDTH), .REGNUM(REGNUM), .ADDRESSWIDTH(AW), .MEMTIMEOUT(MT)) dut (
    .clock(clock), .reset(reset),
    .issueEnable(issueEnable), .issueAddress(issueAddress), .issueFull(issueFull),
    .inValid(inValid), .inReady(inReady), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
    .inWriteAddress(inWriteAddress), .inAluResult(inAluResult),
    .memDataValid(memDataValid), .memData(memData),
    .reg1Address(reg1Address), .reg2Address(reg2Address),
    .reg1Busy(reg1Busy), .reg2Busy(reg2Busy),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .dataToSave(dataToSave),
    .pendingMask(pendingMask), .memError(memError)
  );

  always #5 clock = ~clock;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model: pending-write counts, one in-flight instruction slot.
  int         m_cnt [REGNUM];
  bit         m_loading, m_commit, m_err;
  int         m_wait;
  logic [2:0] m_addr;
  logic [7:0] m_data;

  typedef struct {
    logic       ie;
    logic [2:0] ia;
    logic       iv;
    logic       rw;
    logic       m2r;
    logic [2:0] wa_in;
    logic [7:0] alu;
    logic       exp_we;
    logic [2:0] exp_wa;
    logic [7:0] exp_wd;
    logic       exp_rdy;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REGNUM; i++) m_cnt[i] = 0;
    m_loading = 0; m_commit = 0; m_err = 0; m_wait = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic idle_inputs();
    issueEnable = 0; issueAddress = 0; inValid = 0; inRegWrite = 0; inMemToReg = 0;
    inWriteAddress = 0; inAluResult = 0; memDataValid = 0; memData = 0;
    reg1Address = 0; reg2Address = 0;
  endtask

  task automatic rand_inputs();
    issueEnable = 1'($urandom); issueAddress = 3'($urandom);
    inValid = 1'($urandom); inRegWrite = ($urandom_range(0, 4) != 0);
    inMemToReg = ($urandom_range(0, 4) < 2); inWriteAddress = 3'($urandom);
    inAluResult = 8'($urandom); memDataValid = ($urandom_range(0, 5) == 0);
    memData = 8'($urandom); reg1Address = 3'($urandom); reg2Address = 3'($urandom);
  endtask

  task automatic check_all();
    logic [7:0] em;
    if (!reset) model_reset();
    em = '0;
    for (int i = 0; i < REGNUM; i++) em[i] = (m_cnt[i] != 0);
    chk("inReady", inReady, !m_loading);
    chk("writeEnable", writeEnable, m_commit);
    if (m_commit) begin
      chk("writeAddress", writeAddress, m_addr);
      chk("dataToSave", dataToSave, m_data);
      $display("write r%0d <= 0x%02h", writeAddress, dataToSave);
    end
    if (!reset) begin
      chk("reset_writeAddress", writeAddress, 0);
      chk("reset_dataToSave", dataToSave, 0);
    end
    chk("memError", memError, m_err);
    chk("pendingMask", pendingMask, em);
    chk("reg1Busy", reg1Busy, m_cnt[reg1Address] != 0);
    chk("reg2Busy", reg2Busy, m_cnt[reg2Address] != 0);
    chk("issueFull", issueFull, m_cnt[issueAddress] == 3);
  endtask

  task automatic model_update();
    bit         dec, nc;
    logic [2:0] da;
    if (!reset) begin
      model_reset();
      return;
    end
    dec = m_commit; da = m_addr; nc = 0;
    if (m_loading) begin
      if (memDataValid) begin
        m_data = memData; nc = 1; m_loading = 0;
      end else if (m_wait + 1 == MT) begin
        m_err = 1; m_loading = 0; dec = 1;
      end else begin
        m_wait++;
      end
    end else if (inValid && inRegWrite) begin
      m_addr = inWriteAddress;
      if (!inMemToReg) begin
        m_data = inAluResult; nc = 1;
      end else begin
        m_loading = 1; m_wait = 0;
      end
    end
    if (!(issueEnable && dec && issueAddress == da)) begin
      if (issueEnable && m_cnt[issueAddress] < 3) m_cnt[issueAddress]++;
      if (dec && m_cnt[da] > 0) m_cnt[da]--;
    end
    m_commit = nc;
  endtask

  task automatic to_neg();
    @(negedge clock);
    check_all();
  endtask

  task automatic to_pos();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic do_reset();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      to_neg();
      chk("rst_inReady", inReady, 1);
      chk("rst_writeEnable", writeEnable, 0);
      chk("rst_mask", pendingMask, 0);
      chk("rst_issueFull", issueFull, 0);
      chk("rst_memError", memError, 0);
      to_pos();
    end
    idle_inputs();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      to_neg();
      chk("post_rst_no_write", writeEnable, 0);
      to_pos();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit we_seen;
    idle_inputs();
    model_reset();
    #1;

    //        ie ia iv rw m2r wa  alu    we wa  wd     rdy mask
    tbl[0]  = '{1, 3, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00};
    tbl[1]  = '{0, 0, 1, 1, 0, 3, 8'h5A, 0, 0, 8'h00, 1, 8'h08};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 8'h00, 1, 3, 8'h5A, 1, 8'h08};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h01};
    tbl[6]  = '{1, 2, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h03};
    tbl[7]  = '{1, 3, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h07};
    tbl[8]  = '{0, 0, 1, 1, 0, 0, 8'h10, 0, 0, 8'h00, 1, 8'h0F};
    tbl[9]  = '{0, 0, 1, 1, 0, 1, 8'h11, 1, 0, 8'h10, 1, 8'h0F};
    tbl[10] = '{0, 0, 1, 1, 0, 2, 8'h12, 1, 1, 8'h11, 1, 8'h0E};
    tbl[11] = '{0, 0, 1, 1, 0, 3, 8'h13, 1, 2, 8'h12, 1, 8'h0C};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 8'h00, 1, 3, 8'h13, 1, 8'h08};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00};

    do_reset();

    // ALU path and back-to-back writes
    for (int v = 0; v < 14; v++) begin
      idle_inputs();
      issueEnable = tbl[v].ie; issueAddress = tbl[v].ia;
      inValid = tbl[v].iv; inRegWrite = tbl[v].rw; inMemToReg = tbl[v].m2r;
      inWriteAddress = tbl[v].wa_in; inAluResult = tbl[v].alu;
      reg1Address = 3;
      to_neg();
      $display("vector %0d: we=%0b wa=%0d wd=0x%02h mask=0x%02h", v, writeEnable, writeAddress,
               dataToSave, pendingMask);
      chk($sformatf("tbl%0d_we", v), writeEnable, tbl[v].exp_we);
      if (tbl[v].exp_we) begin
        chk($sformatf("tbl%0d_wa", v), writeAddress, tbl[v].exp_wa);
        chk($sformatf("tbl%0d_wd", v), dataToSave, tbl[v].exp_wd);
      end
      chk($sformatf("tbl%0d_rdy", v), inReady, tbl[v].exp_rdy);
      chk($sformatf("tbl%0d_mask", v), pendingMask, tbl[v].exp_mask);
      chk($sformatf("tbl%0d_busy1", v), reg1Busy, tbl[v].exp_mask[3]);
      to_pos();
    end

    // Load path: data four cycles after accept
    do_reset();
    issueEnable = 1; issueAddress = 5; tick(); idle_inputs();
    inValid = 1; inRegWrite = 1; inMemToReg = 1; inWriteAddress = 5; tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      to_neg(); chk("load_wait_ready", inReady, 0); to_pos();
    end
    memDataValid = 1; memData = 8'hC3;
    to_neg(); chk("load_valid_ready", inReady, 0); to_pos();
    idle_inputs();
    to_neg();
    chk("load_we", writeEnable, 1);
    chk("load_wa", writeAddress, 5);
    chk("load_wd", dataToSave, 8'hC3);
    chk("load_ready_back", inReady, 1);
    $display("load r5 committed data 0x%02h", dataToSave);
    to_pos();
    to_neg(); chk("load_busy_clear", pendingMask[5], 0); to_pos();

    // Load timeout
    do_reset();
    issueEnable = 1; issueAddress = 2; tick(); idle_inputs();
    inValid = 1; inRegWrite = 1; inMemToReg = 1; inWriteAddress = 2; tick(); idle_inputs();
    k = 0; we_seen = 0;
    while (k < MT + 5) begin
      to_neg();
      k++;
      if (writeEnable) we_seen = 1;
      if (memError) break;
      to_pos();
    end
    chk("timeout_cycles", k, MT + 1);
    chk("timeout_no_write", we_seen, 0);
    chk("timeout_mask2", pendingMask[2], 0);
    chk("timeout_ready", inReady, 1);
    $display("load r2 timed out after %0d cycles", k - 1);
    to_pos();
    for (int i = 0; i < 100; i++) tick();
    to_neg(); chk("timeout_sticky", memError, 1); to_pos();

    // Scoreboard saturation and same-cycle issue/commit
    do_reset();
    issueEnable = 1; issueAddress = 1;
    for (int i = 0; i < 3; i++) tick();
    to_neg(); chk("sb_full", issueFull, 1); to_pos();
    idle_inputs(); issueAddress = 1;
    to_neg(); chk("sb_fourth_ignored", issueFull, 1); to_pos();
    inValid = 1; inRegWrite = 1; inWriteAddress = 1; inAluResult = 8'h77; tick();
    idle_inputs(); issueEnable = 1; issueAddress = 1;
    to_neg(); chk("sb_commit_we", writeEnable, 1); to_pos();
    idle_inputs(); issueAddress = 1;
    to_neg(); chk("sb_stays_full", issueFull, 1); to_pos();
    for (int i = 0; i < 3; i++) begin
      inValid = 1; inRegWrite = 1; inWriteAddress = 1; inAluResult = 8'(8'h80 + i); tick();
    end
    idle_inputs(); tick();
    to_neg(); chk("sb_drained", pendingMask, 0); to_pos();
    $display("scoreboard r1 saturate/drain sequence done");

    // Randomized run, including occasional asynchronous resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1; idle_inputs(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
